// File: rtl/bnn_image_feeder.sv
// Host-side pixel streamer for the BinarizedNeuralNetwork serial port.
// Buffers one binarized image, streams it on rcv_ack, fetches the class.
module bnn_image_feeder #(
  parameter int PIXEL_NUM = 784,
  parameter int WORD_W    = 16,
  parameter int CLASS_W   = 4,
  parameter int TIMEOUT   = 65535,
  localparam int NWORDS   = (PIXEL_NUM + WORD_W - 1) / WORD_W,
  localparam int AW       = $clog2(NWORDS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [WORD_W-1:0]  wr_data,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [CLASS_W-1:0] result,
  output logic               pix_out,
  input  logic               rcv_req,
  output logic               rcv_ack,
  output logic               snd_req,
  input  logic               snd_ack,
  input  logic [CLASS_W-1:0] cls_in
);

  localparam int CW = $clog2(PIXEL_NUM);

  typedef enum logic [2:0] {
    IDLE, WAIT_REQ, GAP, STREAM, RESULT, RELEASE, FINISH
  } state_t;

  state_t state, state_n;

  logic [WORD_W-1:0]  mem [NWORDS];
  logic [CW-1:0]      cnt, cnt_n;
  logic [15:0]        wd, wd_n, wd_inc;
  logic               wd_hit;
  logic [CW-1:0]      idx, widx, bidx;
  logic               pix_next;
  logic               busy_n, done_n, err_n;
  logic               ack_n, req_n, pix_n;
  logic [CLASS_W-1:0] res_n;

  // Image buffer: host writes land only while idle, never reset.
  always_ff @(posedge clk) begin
    if (wr_en && state == IDLE && wr_addr < AW'(NWORDS))
      mem[wr_addr] <= wr_data;
  end

  // Pixel to present on the next stream cycle (LSB-first per word).
  always_comb begin
    idx      = (state == GAP) ? '0 : cnt + 1'b1;
    widx     = idx / CW'(WORD_W);
    bidx     = idx % CW'(WORD_W);
    pix_next = mem[widx[AW-1:0]][bidx[$clog2(WORD_W)-1:0]];
  end

  // Saturating watchdog; TIMEOUT of zero disables expiry.
  always_comb begin
    wd_inc = (wd == 16'hFFFF) ? wd : wd + 16'd1;
    wd_hit = (TIMEOUT != 0) && (wd == 16'(TIMEOUT));
  end

  // Next-state and next-output decode; outputs are all registered.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    busy_n  = busy;
    done_n  = 1'b0;
    err_n   = 1'b0;
    ack_n   = 1'b0;
    req_n   = 1'b0;
    pix_n   = 1'b0;
    res_n   = result;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = WAIT_REQ;
          busy_n  = 1'b1;
        end
      end
      WAIT_REQ: begin
        if (rcv_req) begin
          state_n = GAP;
        end else if (wd_hit) begin
          state_n = FINISH;
          done_n  = 1'b1;
          err_n   = 1'b1;
          busy_n  = 1'b0;
        end
      end
      GAP: begin
        state_n = STREAM;
        cnt_n   = '0;
        ack_n   = 1'b1;
        pix_n   = pix_next;
      end
      STREAM: begin
        if (cnt == CW'(PIXEL_NUM - 1)) begin
          state_n = RESULT;
          req_n   = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
          ack_n = 1'b1;
          pix_n = pix_next;
        end
      end
      RESULT: begin
        req_n = 1'b1;
        if (snd_ack) begin
          state_n = RELEASE;
          res_n   = cls_in;
        end else if (wd_hit) begin
          state_n = FINISH;
          req_n   = 1'b0;
          done_n  = 1'b1;
          err_n   = 1'b1;
          busy_n  = 1'b0;
        end
      end
      RELEASE: begin
        state_n = FINISH;
        done_n  = 1'b1;
        busy_n  = 1'b0;
      end
      FINISH: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
    wd_n = (state_n != state) ? 16'd0 : wd_inc;
  end

  // State, counters and registered outputs; reset aborts any transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      wd      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      rcv_ack <= 1'b0;
      snd_req <= 1'b0;
      pix_out <= 1'b0;
      result  <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      wd      <= wd_n;
      busy    <= busy_n;
      done    <= done_n;
      err     <= err_n;
      rcv_ack <= ack_n;
      snd_req <= req_n;
      pix_out <= pix_n;
      result  <= res_n;
    end
  end

endmodule

// File: tb/tb_bnn_image_feeder.sv
// Directed bench for bnn_image_feeder.
// Second instance with a short watchdog covers the timeout path.
module tb_bnn_image_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [15:0] wr_data;
  logic        start, start_wd;
  logic        busy, done, err, pix_out;
  logic        rcv_req, rcv_ack, snd_req, snd_ack;
  logic [3:0]  result, cls_in;
  logic        busy_wd, done_wd, err_wd, pix_wd;
  logic        ack_wd, req_wd;
  logic [3:0]  result_wd;
  logic        zero1 = 1'b0;
  logic [3:0]  zero4 = 4'd0;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [15:0] img [49];

  bnn_image_feeder dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .busy(busy), .done(done), .err(err),
    .result(result), .pix_out(pix_out),
    .rcv_req(rcv_req), .rcv_ack(rcv_ack),
    .snd_req(snd_req), .snd_ack(snd_ack), .cls_in(cls_in)
  );

  bnn_image_feeder #(.TIMEOUT(16)) dut_wd (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start_wd), .busy(busy_wd), .done(done_wd),
    .err(err_wd), .result(result_wd), .pix_out(pix_wd),
    .rcv_req(zero1), .rcv_ack(ack_wd),
    .snd_req(req_wd), .snd_ack(zero1), .cls_in(zero4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) done_cnt++;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic pix_exp(int n);
    logic [15:0] w;
    w = img[n / 16];
    return w[n % 16];
  endfunction

  task automatic wr(input int a, input logic [15:0] d);
    wr_en   = 1'b1;
    wr_addr = 6'(a);
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic load_img();
    for (int w = 0; w < 49; w++) wr(w, img[w]);
  endtask

  // Pulse start; return cycles from the start edge to first rcv_ack.
  task automatic go(output int lat);
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    while (rcv_ack !== 1'b1 && lat < 300) begin
      tick();
      lat++;
    end
  endtask

  // Check the stream against img, then play the network's result side:
  // snd_ack rises in the 5th snd_req cycle, so snd_req spans 6 cycles.
  task automatic finish_run(input string tag, input logic [3:0] cls,
                            input int inj);
    int n, bad, rq;
    n = 0;
    bad = 0;
    while (rcv_ack === 1'b1 && n < 1000) begin
      if (pix_out !== pix_exp(n)) bad++;
      if (n == inj) begin
        wr_en = 1'b1; wr_addr = 6'd3; wr_data = 16'hFFFF;
        start = 1'b1;
      end
      tick();
      wr_en = 1'b0;
      start = 1'b0;
      n++;
    end
    chk({tag, "_len"}, n, 784);
    chk({tag, "_pix"}, bad, 0);
    chk({tag, "_req_on"}, snd_req, 1);
    chk({tag, "_pix_off"}, pix_out, 0);
    cls_in = cls;
    rq = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (snd_req === 1'b1) rq++;
    end
    snd_ack = 1'b1;
    tick();
    if (snd_req === 1'b1) rq++;
    snd_ack = 1'b0;
    chk({tag, "_result"}, result, cls);
    tick();
    chk({tag, "_req_len"}, rq, 6);
    chk({tag, "_req_off"}, snd_req, 0);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_off"}, busy, 0);
    chk({tag, "_err"}, err, 0);
    tick();
    chk({tag, "_done_off"}, done, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int lat, d0, bad;
    rst = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; start_wd = 1'b0;
    rcv_req = 1'b0; snd_ack = 1'b0; cls_in = '0;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ack", rcv_ack, 0);
    chk("rst_req", snd_req, 0);
    chk("rst_pix", pix_out, 0);
    chk("rst_result", result, 0);
    rst = 1'b0;
    tick();

    // Alternating 0,1 pixels, network already requesting.
    for (int w = 0; w < 49; w++) img[w] = 16'hAAAA;
    load_img();
    rcv_req = 1'b1;
    go(lat);
    chk("alt_lat", lat, 2);
    chk("alt_busy", busy, 1);
    finish_run("alt", 4'd1, -1);

    // Checkerboard, class 7.
    for (int k = 0; k < 784; k++)
      img[k / 16][k % 16] = 1'((k / 28 + k % 28) % 2);
    load_img();
    go(lat);
    chk("chk_lat", lat, 2);
    finish_run("chk", 4'd7, -1);

    // Network not ready for 100 cycles.
    rcv_req = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (rcv_ack !== 1'b0) bad++;
      tick();
    end
    chk("late_noack", bad, 0);
    rcv_req = 1'b1;
    tick();
    chk("late_ack1", rcv_ack, 0);
    tick();
    chk("late_ack2", rcv_ack, 1);
    finish_run("late", 4'd2, -1);

    // Write and start during the stream are ignored.
    go(lat);
    finish_run("ign", 4'd4, 100);
    chk("ign_done_once", busy, 0);
    img[3] = 16'hFFFF;
    wr(3, 16'hFFFF);
    go(lat);
    finish_run("neww", 4'd6, -1);

    // Reset in the middle of an all-ones stream.
    for (int w = 0; w < 49; w++) img[w] = 16'hFFFF;
    load_img();
    go(lat);
    for (int i = 0; i < 400; i++) tick();
    chk("mid_pix_pre", pix_out, 1);
    rst = 1'b1;
    #1;
    chk("mid_ack", rcv_ack, 0);
    chk("mid_busy", busy, 0);
    chk("mid_pix", pix_out, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("mid_idle", busy, 0);
    go(lat);
    chk("rerun_lat", lat, 2);
    finish_run("rerun", 4'd5, -1);

    // Back-to-back images, start right after done.
    d0 = done_cnt;
    go(lat);
    finish_run("b2b3", 4'd3, -1);
    go(lat);
    chk("b2b_lat", lat, 2);
    finish_run("b2b9", 4'd9, -1);
    chk("b2b_dones", done_cnt - d0, 2);

    // Watchdog with TIMEOUT=16, rcv_req never asserted.
    start_wd = 1'b1;
    tick();
    start_wd = 1'b0;
    chk("wd_busy", busy_wd, 1);
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (done_wd !== 1'b0) bad++;
    end
    chk("wd_early", bad, 0);
    tick();
    chk("wd_done", done_wd, 1);
    chk("wd_err", err_wd, 1);
    chk("wd_busy_off", busy_wd, 0);
    chk("wd_result", result_wd, 0);
    chk("wd_noack", ack_wd, 0);
    tick();
    chk("wd_done_off", done_wd, 0);
    start_wd = 1'b1;
    tick();
    start_wd = 1'b0;
    chk("wd_restart", busy_wd, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/bnn_image_feeder.md
Name: bnn_image_feeder

Overview:
- Host-side initiator for the BinarizedNeuralNetwork serial pixel port; the synthesizable counterpart of the simulation driver.
- Host writes one binarized 28x28 image into an internal word buffer, then pulses start.
- The block then waits for the network's rcv_req, streams PIXEL_NUM pixels with rcv_ack, requests the result via snd_req/snd_ack, and latches the 4-bit class.
- Sits between a host register/bus interface and one BinarizedNeuralNetwork instance.

Parameters:
PIXEL_NUM, 784, pixels per image (28*28)
WORD_W, 16, host write word width; pixel i = word i/WORD_W, bit i%WORD_W (LSB first)
CLASS_W, 4, class result width
TIMEOUT, 65535, max wait cycles for rcv_req or snd_ack; 0 disables the watchdog

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
wr_en  in  1  host buffer write strobe
wr_addr  in  ceil(PIXEL_NUM/WORD_W) addr bits (6)  word index 0..48
wr_data  in  WORD_W  pixel word
start  in  1  one-cycle pulse; begin classification
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse when result is valid
err  out  1  one-cycle pulse on watchdog expiry (with done)
result  out  CLASS_W  last captured class, held until next capture
pix_out  out  1  to network inputs
rcv_req  in  1  network ready to receive
rcv_ack  out  1  pixel valid strobe
snd_req  out  1  result request to network
snd_ack  in  1  network result valid
cls_in  in  CLASS_W  network outputs

Behaviour:
- Reset (async): busy, done, err, rcv_ack, snd_req, pix_out = 0; result = 0; FSM = IDLE; counters cleared; buffer contents are not cleared.
- All outputs are registered.
- Buffer writes commit only in IDLE.
- wr_en while busy is ignored. wr_addr >= 49 is ignored. Bits beyond PIXEL_NUM in word 48 are unused.
- FSM transitions:
  - IDLE: start=1 -> WAIT_REQ (busy=1 next cycle). start while busy is ignored. wr_en and start in the same IDLE cycle: the write commits and the stream uses the new data.
  - WAIT_REQ: rcv_req sampled 1 -> GAP. Watchdog counts; on reaching TIMEOUT -> FINISH with err.
  - GAP: exactly one idle cycle, rcv_ack=0 -> STREAM.
  - STREAM: rcv_ack=1 for exactly PIXEL_NUM consecutive cycles; during stream cycle k (0..783), pix_out = pixel[k]. rcv_req is not re-checked during the stream. After cycle 783, rcv_ack=0 and pix_out=0 in the same cycle snd_req goes 1 -> RESULT.
  - RESULT: snd_req held 1. On the edge where snd_ack is sampled 1, result <= cls_in -> RELEASE. Watchdog: same rule as WAIT_REQ, result is unchanged on expiry.
  - RELEASE: snd_req stays 1 for this one cycle, then 0 -> FINISH.
  - FINISH: done=1 (plus err if timed out) for one cycle, busy=0 in the same cycle -> IDLE.
- Pixel counter: 10 bits, counts 0..PIXEL_NUM-1, no wrap; it is the exit condition of STREAM.
- Watchdog counter: 16 bits, cleared on each state entry, saturating.
- Reset mid-operation forces all outputs to 0 immediately (rcv_ack/snd_req drop asynchronously); the partial stream is abandoned.
- snd_ack high outside RESULT is ignored. rcv_req dropping mid-stream is ignored.
- Latency, with rcv_req already high: start edge t -> first rcv_ack cycle at t+3 -> last at t+786 -> snd_req from t+787.

Test Plan:
- Write all 49 words 0xAAAA, start, rcv_req=1 -> rcv_ack high exactly 784 cycles, pix_out alternates 0,1,0,1... starting at 0, first ack at start+3.
- Checkerboard image from a file-loaded model; network model returns class 7 with snd_ack 5 cycles after snd_req -> result=7, done pulse once, snd_req high 6 cycles then low, busy low with done.
- rcv_req held low 100 cycles after start -> no rcv_ack until 2 edges after rcv_req rises; TIMEOUT=16 with rcv_req never high -> err=done=1 at start+18, result unchanged, FSM back in IDLE.
- wr_en with 0xFFFF to addr 3 during STREAM, and a second start mid-stream -> both ignored; the stream uses the old data; a later run after IDLE sees the new word.
- rst asserted at stream cycle 400 -> rcv_ack, busy, pix_out 0 immediately; after release a new start gives a full 784-cycle stream.
- Two back-to-back images (classes 3 then 9) with start on the cycle after done -> result 3 then 9, exactly two done pulses.
